// File: rtl/countdown_timer.sv
// countdown_timer
// Decrementing hh:mm:ss timer with a valid/ready load port, start/pause/clear
// controls, a one-second prescaler, a one-cycle expiry pulse and a done level.
// Field widths and ranges match the up-counting time counter so both can share
// the same display path.

module countdown_timer #(
  parameter int TICK_DIV = 4,
  parameter int PW       = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load_valid,
  output logic       o_load_ready,
  input  logic [4:0] i_load_hr,
  input  logic [6:0] i_load_min,
  input  logic [6:0] i_load_sec,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_clear,
  output logic [4:0] o_hr,
  output logic [6:0] o_min,
  output logic [6:0] o_sec,
  output logic       o_running,
  output logic       o_expired,
  output logic       o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [4:0]    HR_MAX    = 5'd23;
  localparam logic [6:0]    MS_MAX    = 7'd59;

  state_t        r_state;
  state_t        w_nextState;
  logic [4:0]    r_hr;
  logic [6:0]    r_min;
  logic [6:0]    r_sec;
  logic [PW-1:0] r_presc;
  logic          r_expired;

  logic [4:0]    w_nextHr;
  logic [6:0]    w_nextMin;
  logic [6:0]    w_nextSec;
  logic [PW-1:0] w_nextPresc;
  logic          w_nextExpired;

  logic          w_timeZero;
  logic          w_tick;
  logic          w_loadFire;
  logic [4:0]    w_satHr;
  logic [6:0]    w_satMin;
  logic [6:0]    w_satSec;
  logic [4:0]    w_decHr;
  logic [6:0]    w_decMin;
  logic [6:0]    w_decSec;
  logic          w_decZero;

  // The count is accepted only while the timer is not actively running.
  assign o_load_ready = (r_state != ST_RUN);
  assign w_loadFire   = i_load_valid && o_load_ready;

  assign w_timeZero = (r_hr == 5'd0) && (r_min == 7'd0) && (r_sec == 7'd0);
  assign w_tick     = (r_presc == TICK_LAST);

  // Clamp loaded fields to the legal display range.
  assign w_satHr  = (i_load_hr  > HR_MAX) ? HR_MAX : i_load_hr;
  assign w_satMin = (i_load_min > MS_MAX) ? MS_MAX : i_load_min;
  assign w_satSec = (i_load_sec > MS_MAX) ? MS_MAX : i_load_sec;

  // One-second decrement with borrow from seconds into minutes into hours.
  always_comb begin
    w_decHr  = r_hr;
    w_decMin = r_min;
    w_decSec = r_sec;
    if (r_sec != 7'd0) begin
      w_decSec = r_sec - 7'd1;
    end else if (r_min != 7'd0) begin
      w_decSec = MS_MAX;
      w_decMin = r_min - 7'd1;
    end else if (r_hr != 5'd0) begin
      w_decSec = MS_MAX;
      w_decMin = MS_MAX;
      w_decHr  = r_hr - 5'd1;
    end
    w_decZero = (w_decHr == 5'd0) && (w_decMin == 7'd0) && (w_decSec == 7'd0);
  end

  // Next state and datapath: clear beats load, load beats pause, pause beats start/tick.
  always_comb begin
    w_nextState   = r_state;
    w_nextHr      = r_hr;
    w_nextMin     = r_min;
    w_nextSec     = r_sec;
    w_nextPresc   = r_presc;
    w_nextExpired = 1'b0;

    if (i_clear) begin
      w_nextState = ST_IDLE;
      w_nextHr    = 5'd0;
      w_nextMin   = 7'd0;
      w_nextSec   = 7'd0;
      w_nextPresc = '0;
    end else if (w_loadFire) begin
      w_nextHr    = w_satHr;
      w_nextMin   = w_satMin;
      w_nextSec   = w_satSec;
      w_nextPresc = '0;
      if (r_state == ST_DONE) begin
        w_nextState = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_pause) begin
            w_nextState = ST_PAUSE;
          end else if (w_tick) begin
            w_nextPresc = '0;
            w_nextHr    = w_decHr;
            w_nextMin   = w_decMin;
            w_nextSec   = w_decSec;
            if (w_decZero) begin
              w_nextState   = ST_DONE;
              w_nextExpired = 1'b1;
            end
          end else begin
            w_nextPresc = r_presc + PW'(1);
          end
        end
        ST_IDLE: begin
          if (!i_pause && i_start && !w_timeZero) begin
            w_nextState = ST_RUN;
            w_nextPresc = '0;
          end
        end
        ST_PAUSE: begin
          if (!i_pause && i_start && !w_timeZero) begin
            w_nextState = ST_RUN;
          end
        end
        ST_DONE: begin
          w_nextState = ST_DONE;
        end
        default: begin
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

  // State, time fields, prescaler and expiry pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_hr      <= 5'd0;
      r_min     <= 7'd0;
      r_sec     <= 7'd0;
      r_presc   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_hr      <= w_nextHr;
      r_min     <= w_nextMin;
      r_sec     <= w_nextSec;
      r_presc   <= w_nextPresc;
      r_expired <= w_nextExpired;
    end
  end

  assign o_hr      = r_hr;
  assign o_min     = r_min;
  assign o_sec     = r_sec;
  assign o_running = (r_state == ST_RUN);
  assign o_done    = (r_state == ST_DONE);
  assign o_expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
// Directed and randomized bench for countdown_timer. A behavioural model keeps
// the remaining time as a single number of seconds plus a cycle count since the
// last tick; a compare process checks every DUT output against it on each
// falling edge, and directed steps pin the model with literal expectations.

module tb_countdown_timer;

  localparam int TICK_DIV = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [4:0] load_hr = '0;
  logic [6:0] load_min = '0;
  logic [6:0] load_sec = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] hr;
  logic [6:0] min;
  logic [6:0] sec;
  logic       running;
  logic       expired;
  logic       done;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;

  int mTotal = 0;
  int mPhase = 0;
  int mState = M_IDLE;
  bit mExpired = 1'b0;

  countdown_timer #(.TICK_DIV(TICK_DIV), .PW(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_load_valid(load_valid),
    .o_load_ready(load_ready),
    .i_load_hr   (load_hr),
    .i_load_min  (load_min),
    .i_load_sec  (load_sec),
    .i_start     (start),
    .i_pause     (pause),
    .i_clear     (clear),
    .o_hr        (hr),
    .o_min       (min),
    .o_sec       (sec),
    .o_running   (running),
    .o_expired   (expired),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit lv, input int h, input int m, input int s,
                               input bit st, input bit pa, input bit cl);
    load_valid = lv;
    load_hr    = 5'(h);
    load_min   = 7'(m);
    load_sec   = 7'(s);
    start      = st;
    pause      = pa;
    clear      = cl;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model: remaining time as total seconds, cycles counted per tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mTotal = 0;
      mPhase = 0;
      mState = M_IDLE;
      mExpired = 1'b0;
    end else begin
      mExpired = 1'b0;
      if (clear) begin
        mTotal = 0;
        mPhase = 0;
        mState = M_IDLE;
      end else if (load_valid && mState != M_RUN) begin
        mTotal = sat(load_hr, 23) * 3600 + sat(load_min, 59) * 60 + sat(load_sec, 59);
        mPhase = 0;
        if (mState == M_DONE) mState = M_IDLE;
      end else if (mState == M_RUN) begin
        if (pause) begin
          mState = M_PAUSE;
        end else begin
          mPhase++;
          if (mPhase == TICK_DIV) begin
            mPhase = 0;
            mTotal--;
            if (mTotal == 0) begin
              mState = M_DONE;
              mExpired = 1'b1;
            end
          end
        end
      end else if ((mState == M_IDLE || mState == M_PAUSE) && !pause && start && mTotal != 0) begin
        if (mState == M_IDLE) mPhase = 0;
        mState = M_RUN;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("hr",         hr,         mTotal / 3600);
      checkOutput("min",        min,        (mTotal / 60) % 60);
      checkOutput("sec",        sec,        mTotal % 60);
      checkOutput("running",    running,    int'(mState == M_RUN));
      checkOutput("done",       done,       int'(mState == M_DONE));
      checkOutput("load_ready", load_ready, int'(mState != M_RUN));
      checkOutput("expired",    expired,    int'(mExpired));
    end
  end

  initial begin
    idle();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hr", hr, 0);
    checkOutput("rst_sec", sec, 0);
    checkOutput("rst_ready", load_ready, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_expired", expired, 0);
    rst_n = 1'b1;
    checkEn = 1'b1;

    // Load 0:0:3 and count to expiry.
    applyStimulus(1, 0, 0, 3, 0, 0, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    cycle();
    idle();
    repeat (3) cycle();
    checkOutput("cnt_sec_3", sec, 3);
    cycle();
    checkOutput("cnt_sec_2", sec, 2);
    repeat (4) cycle();
    checkOutput("cnt_sec_1", sec, 1);
    repeat (4) cycle();
    checkOutput("cnt_sec_0", sec, 0);
    checkOutput("cnt_expired", expired, 1);
    checkOutput("cnt_done", done, 1);
    checkOutput("cnt_running", running, 0);
    cycle();
    checkOutput("cnt_expired_drop", expired, 0);
    checkOutput("cnt_done_hold", done, 1);

    // Load 1:00:00 from DONE, borrow across hours.
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    cycle();
    checkOutput("done_load_done", done, 0);
    checkOutput("done_load_ready", load_ready, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    cycle();
    idle();
    repeat (4) cycle();
    checkOutput("borrow_hr", hr, 0);
    checkOutput("borrow_min", min, 59);
    checkOutput("borrow_sec", sec, 59);

    // Pause, load 0:1:0 while paused, resume, borrow across minutes.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    cycle();
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    cycle();
    idle();
    repeat (4) cycle();
    checkOutput("borrow2_min", min, 0);
    checkOutput("borrow2_sec", sec, 59);

    // Saturating load, then a load attempt while running is refused.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    cycle();
    applyStimulus(1, 31, 99, 60, 0, 0, 0);
    cycle();
    checkOutput("sat_hr", hr, 23);
    checkOutput("sat_min", min, 59);
    checkOutput("sat_sec", sec, 59);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    cycle();
    applyStimulus(1, 1, 2, 3, 0, 0, 0);
    cycle();
    checkOutput("run_ready", load_ready, 0);
    checkOutput("run_hr_kept", hr, 23);
    checkOutput("run_sec_kept", sec, 59);

    // Pause mid-prescale for 10 cycles, then resume with the remaining count.
    idle();
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    repeat (10) cycle();
    checkOutput("pause_sec", sec, 59);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    cycle();
    idle();
    cycle();
    checkOutput("resume_sec_hold", sec, 59);
    cycle();
    checkOutput("resume_sec_tick", sec, 58);

    // Pause on the cycle a tick would land: no decrement.
    repeat (3) cycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    cycle();
    checkOutput("pause_tick_sec", sec, 58);
    checkOutput("pause_tick_run", running, 0);

    // Clear together with load and start while running.
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    cycle();
    applyStimulus(1, 5, 5, 5, 1, 0, 1);
    cycle();
    checkOutput("clr_hr", hr, 0);
    checkOutput("clr_sec", sec, 0);
    checkOutput("clr_run", running, 0);
    checkOutput("clr_expired", expired, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    cycle();
    checkOutput("zero_start_run", running, 0);

    // Asynchronous reset between edges mid-count.
    applyStimulus(1, 0, 0, 5, 0, 0, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    cycle();
    idle();
    repeat (2) cycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_sec", sec, 0);
    checkOutput("arst_run", running, 0);
    checkOutput("arst_ready", load_ready, 1);
    cycle();
    rst_n = 1'b1;

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      int h, m, s;
      if ($urandom_range(0, 3) == 0) begin
        h = $urandom_range(0, 31);
        m = $urandom_range(0, 127);
        s = $urandom_range(0, 127);
      end else begin
        h = 0;
        m = $urandom_range(0, 1);
        s = $urandom_range(0, 6);
      end
      applyStimulus($urandom_range(0, 7) == 0, h, m, s,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 59) == 0);
      cycle();
    end

    idle();
    repeat (2) cycle();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Decrementing hh:mm:ss timer; the down-counting counterpart of the team's up-counting sec/min/hr time counter.
- Software or the upstream controller loads a duration through a valid/ready handshake, then starts, pauses or clears it.
- The block counts down once per prescaled second and flags expiry.
- Output fields use the same widths and ranges as the time counter, so both drive the same display path.

Parameters:
- TICK_DIV, 4, clk cycles per one-second tick (>=1; 1 = tick every cycle).
- PW, 16, prescaler counter width (must hold TICK_DIV-1).

Ports:
- clk  input  1  system clock, all logic posedge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load request.
- load_ready  output  1  high when a load can be accepted.
- load_hr  input  5  hours to load.
- load_min  input  7  minutes to load.
- load_sec  input  7  seconds to load.
- start  input  1  begin or resume countdown (level sampled each cycle).
- pause  input  1  hold countdown.
- clear  input  1  abort and zero everything.
- hr  output  5  remaining hours.
- min  output  7  remaining minutes.
- sec  output  7  remaining seconds.
- running  output  1  high in RUN.
- expired  output  1  one-cycle pulse at reaching zero.
- done  output  1  level, high in DONE until load/clear.

Behaviour:
- Decided: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: hr=min=sec=0, prescaler=0, state=IDLE, running=0, expired=0, done=0, load_ready=1.
- States: IDLE, RUN, PAUSE, DONE.
- load_ready=1 in IDLE, PAUSE and DONE; 0 in RUN.
- Load transfer occurs when load_valid && load_ready at a clk edge.
- Loaded values are saturated to range: hr>23 becomes 23; min>59 or sec>59 becomes 59.
- A load updates hr/min/sec on the next edge and clears the prescaler.
- A load in DONE moves the state to IDLE and drops done. A load in PAUSE stays in PAUSE.
- Priority per cycle: clear > load > pause > start.
- clear, from any state: hr/min/sec=0, prescaler=0, state to IDLE, done=0. No expired pulse.
- IDLE/PAUSE + start (no pause): go to RUN if the time is nonzero. If the time is 00:00:00, start is ignored.
- start from IDLE resets the prescaler to 0. Resume from PAUSE keeps the prescaler value.
- RUN + pause: go to PAUSE, and the prescaler freezes.
- RUN prescaler: increments each cycle. At TICK_DIV-1 it wraps to 0 and raises an internal tick that same cycle.
- The first decrement after start from IDLE occurs TICK_DIV cycles after the start edge.
- Decrement on tick, with borrow:
  - sec>0: sec-1.
  - sec=0, min>0: sec=59, min-1.
  - sec=min=0, hr>0: hr-1, min=59, sec=59.
- When a tick makes the result 00:00:00, the state goes to DONE on that same edge. expired=1 for exactly that one cycle; done=1 from then on.
- DONE: count is held at zero; start is ignored.
- pause and tick in the same cycle: pause wins and no decrement occurs.
- rst_n low mid-count: immediate return to reset values, with no expired pulse.
- Fields never leave range: sec,min 0..59; hr 0..23.

Test Plan:
- Reset, then load 0:0:3 with TICK_DIV=4, then start -> sec steps 3,2,1,0 at cycles +4,+8,+12. expired pulses for 1 cycle at +12; done=1 stays high; running=0.
- Load 1:00:00, start, 1 tick -> 0:59:59. Load 0:1:0, 1 tick -> 0:0:59.
- Load hr=31, min=99, sec=60 -> readback 23:59:59. load_valid while running -> load_ready=0, values unchanged.
- Run, pause for 10 cycles mid-prescale, then resume -> no decrement while paused. Next tick comes after the remaining prescaler cycles only. pause asserted together with tick -> no decrement.
- clear asserted together with load_valid and start during RUN -> 0:0:0, IDLE, no expired. start with zero time -> stays IDLE.
- Assert rst_n low asynchronously mid-count (between edges) -> outputs zero immediately. Load in DONE -> done drops and state returns to IDLE.
